// File: rtl/pipe_ctrl.sv
// Five-stage core pipeline sequencer: per-cycle enable/flush strobes for the PC and
// the IF/ID, ID/EX, EX/MEM, MEM/WB registers, plus saturating stall/flush counters.
module pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_ren,
    input  logic             mem_wen,
    input  logic             ex_ren,
    input  logic [4:0]       ex_wsel,
    input  logic [4:0]       id_rsel1,
    input  logic [4:0]       id_rsel2,
    input  logic             id_uses_rt,
    input  logic             ex_redirect,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_flush,
    output logic             de_en,
    output logic             de_flush,
    output logic             em_en,
    output logic             em_flush,
    output logic             mw_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DWAIT = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state;
    state_t state_nxt;
    logic   dwait;
    logic   lu;
    logic   stall_take;
    logic   redir_take;

    // Counters stick at all-ones so a long debug run never reads back as a small value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign dwait = (mem_ren | mem_wen) & ~dhit;
    assign lu    = ex_ren & (ex_wsel != 5'd0) &
                   ((ex_wsel == id_rsel1) | (id_uses_rt & (ex_wsel == id_rsel2)));

    always_comb begin
        pc_en      = 1'b0;
        fd_en      = 1'b0;
        fd_flush   = 1'b0;
        de_en      = 1'b0;
        de_flush   = 1'b0;
        em_en      = 1'b0;
        em_flush   = 1'b0;
        mw_en      = 1'b0;
        stall_take = 1'b0;
        redir_take = 1'b0;
        state_nxt  = state;
        case (state)
            BOOT: begin
                fd_flush  = 1'b1;
                de_flush  = 1'b1;
                em_flush  = 1'b1;
                state_nxt = RUN;
            end
            RUN, DWAIT: begin
                state_nxt = RUN;
                if (wb_halt) begin
                    state_nxt = HALT;
                end else if (dwait) begin
                    // Full freeze: a redirect sitting in ID/EX waits here until dhit.
                    stall_take = 1'b1;
                    state_nxt  = DWAIT;
                end else if (ex_redirect) begin
                    pc_en      = 1'b1;
                    fd_flush   = 1'b1;
                    de_flush   = 1'b1;
                    em_en      = 1'b1;
                    mw_en      = 1'b1;
                    redir_take = 1'b1;
                end else if (lu) begin
                    de_flush   = 1'b1;
                    em_en      = 1'b1;
                    mw_en      = 1'b1;
                    stall_take = 1'b1;
                end else if (!ihit) begin
                    fd_flush   = 1'b1;
                    de_en      = 1'b1;
                    em_en      = 1'b1;
                    mw_en      = 1'b1;
                    stall_take = 1'b1;
                end else begin
                    pc_en = 1'b1;
                    fd_en = 1'b1;
                    de_en = 1'b1;
                    em_en = 1'b1;
                    mw_en = 1'b1;
                end
            end
            default: begin
                state_nxt = HALT;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= BOOT;
            halted    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state  <= state_nxt;
            halted <= (state_nxt == HALT);
            if (stall_take) stall_cnt <= sat_inc(stall_cnt);
            if (redir_take) flush_cnt <= sat_inc(flush_cnt);
        end
    end

endmodule
